// File: rtl/wb_dma_copy_pkg.sv
// Shared types and Wishbone bus widths for the word-copy DMA engine.
package wb_dma_copy_pkg;

    localparam int WB_AW = 30;
    localparam int WB_DW = 32;
    localparam int WB_SW = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        FINISH
    } state_t;

endpackage

// File: rtl/wb_dma_copy.sv
// Wishbone pipelined master that copies len words from src to dst, one
// outstanding transaction at a time, with a per-request ack watchdog.
module wb_dma_copy
    import wb_dma_copy_pkg::*;
#(
    parameter int TIMEOUT   = 255,
    parameter int MAX_LEN_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [WB_AW-1:0]     i_src,
    input  logic [WB_AW-1:0]     i_dst,
    input  logic [MAX_LEN_W-1:0] i_len,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    output logic                 wb_cyc,
    output logic                 wb_stb,
    output logic                 wb_we,
    output logic [WB_AW-1:0]     wb_addr,
    output logic [WB_DW-1:0]     wb_mosi,
    output logic [WB_SW-1:0]     wb_sel,
    input  logic                 wb_ack,
    input  logic                 wb_stall,
    input  logic                 wb_err,
    input  logic [WB_DW-1:0]     wb_miso
);

    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [WB_AW-1:0]     src_q, src_d;
    logic [WB_AW-1:0]     dst_q, dst_d;
    logic [MAX_LEN_W-1:0] rem_q, rem_d;
    logic [WB_DW-1:0]     data_q, data_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic                 err_q, err_d;
    logic                 gap_q, gap_d;
    logic                 waiting;
    logic                 bus_fail;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            gap_q   <= gap_d;
        end
    end

    // A watchdog expiry is folded into the same path as a slave error.
    assign waiting  = (state_q == RD_WAIT) || (state_q == WR_WAIT);
    assign bus_fail = wb_err || (waiting && !wb_ack && (wd_q == WD_LAST));

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        data_d  = data_q;
        wd_d    = wd_q;
        err_d   = err_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    src_d   = i_src;
                    dst_d   = i_dst;
                    rem_d   = i_len;
                    err_d   = 1'b0;
                    gap_d   = 1'b0;
                    state_d = (i_len != '0) ? RD_REQ : FINISH;
                end
            end
            RD_REQ, WR_REQ: begin
                // gap_q holds RD_REQ idle for one cyc-low cycle between words
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (wb_err) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else if (!wb_stall) begin
                    wd_d    = '0;
                    state_d = (state_q == RD_REQ) ? RD_WAIT : WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus_fail) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else if (wb_ack) begin
                    data_d  = wb_miso;
                    state_d = WR_REQ;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            WR_WAIT: begin
                if (bus_fail) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else if (wb_ack) begin
                    src_d = src_q + WB_AW'(1);
                    dst_d = dst_q + WB_AW'(1);
                    rem_d = rem_q - MAX_LEN_W'(1);
                    if (rem_q != MAX_LEN_W'(1)) begin
                        gap_d   = 1'b1;
                        state_d = RD_REQ;
                    end else begin
                        state_d = FINISH;
                    end
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign wb_stb  = ((state_q == RD_REQ) && !gap_q) || (state_q == WR_REQ);
    assign wb_cyc  = wb_stb || waiting;
    assign wb_we   = (state_q == WR_REQ) || (state_q == WR_WAIT);
    assign wb_addr = wb_we ? dst_q : src_q;
    assign wb_mosi = data_q;
    assign wb_sel  = '1;
    assign o_busy  = (state_q != IDLE);
    assign o_done  = (state_q == FINISH);
    assign o_err   = err_q;

endmodule
